// File: rtl/ext_bus_responder.sv
// Responder end of the 16-bit multiplexed off-chip CPU bus.
// Decodes a two-word header and serves single/burst beats from a req/ack memory port.
module ext_bus_responder #(
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] bus_data_i,
  output logic [15:0] bus_data_o,
  output logic        bus_data_oe,
  input  logic        bus_req_i,
  input  logic        bus_dir_i,
  output logic        bus_ack_o,
  output logic        bus_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [23:0] mem_addr_o,
  output logic [15:0] mem_data_o,
  input  logic [15:0] mem_data_i,
  input  logic        mem_ack_i,
  input  logic        mem_err_i
);

  typedef enum logic [3:0] {
    IDLE, HDR1, HACK,
    RD_MEM, RD_TURN, RD_ACK, RD_GAP,
    WR_GAP, WR_MEM, WR_ACK,
    ERR
  } state_t;

  state_t      state, state_n;
  logic        is_wr, is_burst;
  logic [23:0] base;
  logic [3:0]  beat;
  logic [7:0]  tcnt;
  logic [15:0] rdata, wdata;
  logic        last, in_mem, resp_err;

  assign last   = !is_burst || (beat == 4'(BURST_LEN - 1));
  assign in_mem = (state == RD_MEM) || (state == WR_MEM);

  // A simultaneous ack+err counts as an error; a late ack beats the timeout.
  assign resp_err = mem_err_i ||
                    (!mem_ack_i && (tcnt == 8'(TIMEOUT - 1)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      is_wr    <= 1'b0;
      is_burst <= 1'b0;
      base     <= '0;
      beat     <= '0;
      tcnt     <= '0;
      rdata    <= '0;
      wdata    <= '0;
    end else begin
      state <= state_n;
      tcnt  <= (in_mem && state_n == state) ? tcnt + 8'd1 : 8'd0;
      unique case (state)
        IDLE: if (bus_req_i) begin
          is_wr      <= bus_data_i[0];
          is_burst   <= bus_data_i[1];
          base[23:16] <= bus_data_i[15:8];
          beat       <= '0;
        end
        HDR1:   base[15:0] <= bus_data_i;
        RD_MEM: if (mem_ack_i) rdata <= mem_data_i;
        RD_GAP: if (!last) beat <= beat + 4'd1;
        WR_GAP: wdata <= bus_data_i;
        WR_ACK: if (!last) beat <= beat + 4'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus_req_i) state_n = HDR1;
      HDR1:    state_n = HACK;
      HACK:    state_n = is_wr ? WR_GAP : RD_MEM;
      RD_MEM: begin
        if (resp_err)       state_n = ERR;
        else if (mem_ack_i) state_n = RD_TURN;
      end
      RD_TURN: if (bus_dir_i) state_n = RD_ACK;
      RD_ACK:  state_n = RD_GAP;
      RD_GAP:  state_n = last ? IDLE : RD_MEM;
      WR_GAP:  state_n = WR_MEM;
      WR_MEM: begin
        if (resp_err)       state_n = ERR;
        else if (mem_ack_i) state_n = WR_ACK;
      end
      WR_ACK:  state_n = last ? IDLE : WR_GAP;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign mem_req_o  = in_mem;
  assign mem_we_o   = (state == WR_MEM);
  assign mem_addr_o = base + {20'd0, beat};
  assign mem_data_o = wdata;

  assign bus_ack_o = (state == HACK) || (state == RD_ACK) ||
                     (state == WR_ACK);
  assign bus_err_o = (state == ERR);

  assign bus_data_o = (state == RD_ACK || state == RD_GAP) ?
                      rdata : 16'd0;

  // Keep the pads driven across burst beats once the bus has turned.
  assign bus_data_oe = bus_dir_i &&
                       ((state == RD_TURN) || (state == RD_ACK) ||
                        (state == RD_GAP) ||
                        (state == RD_MEM && beat != 4'd0));

endmodule

// File: tb/tb_ext_bus_responder.sv
// Directed bench for ext_bus_responder with a scoreboarded memory model.
// Expected memory ops and read data are queued when each header is sent.
module tb_ext_bus_responder;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [15:0] bus_data_i = '0;
  logic [15:0] bus_data_o;
  logic        bus_data_oe;
  logic        bus_req_i = 1'b0;
  logic        bus_dir_i = 1'b0;
  logic        bus_ack_o;
  logic        bus_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [23:0] mem_addr_o;
  logic [15:0] mem_data_o;
  logic [15:0] mem_data_i = '0;
  logic        mem_ack_i = 1'b0;
  logic        mem_err_i = 1'b0;

  ext_bus_responder dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .bus_data_i  (bus_data_i),
    .bus_data_o  (bus_data_o),
    .bus_data_oe (bus_data_oe),
    .bus_req_i   (bus_req_i),
    .bus_dir_i   (bus_dir_i),
    .bus_ack_o   (bus_ack_o),
    .bus_err_o   (bus_err_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .mem_ack_i   (mem_ack_i),
    .mem_err_i   (mem_err_i)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [23:0] addr;
    logic        we;
    logic [15:0] data;
  } mop_t;

  mop_t        exp_mem[$];
  logic [15:0] exp_rd[$];
  int checks = 0;
  int failures = 0;

  int lat = 2;
  int err_at = 0;
  int req_n = 0;
  bit hang = 1'b0;
  int wcnt = 0;
  mop_t cur;

  function automatic logic [15:0] mem_val(input logic [23:0] a);
    return a[15:0] ^ 16'hA1A0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model: checks each request against the queue, then responds.
  always @(negedge i_clk) begin
    mem_ack_i = 1'b0;
    mem_err_i = 1'b0;
    if (i_rst || !mem_req_o) begin
      wcnt = 0;
    end else begin
      if (wcnt == 0) begin
        req_n++;
        if (exp_mem.size() == 0) begin
          check("mem_unexp", 64'(exp_mem.size()), 64'd1);
        end else begin
          cur = exp_mem.pop_front();
          check("mem_addr", 64'(mem_addr_o), 64'(cur.addr));
          check("mem_we", 64'(mem_we_o), 64'(cur.we));
          if (cur.we)
            check("mem_wdata", 64'(mem_data_o), 64'(cur.data));
        end
      end
      wcnt++;
      if (!hang && wcnt == lat) begin
        if (req_n == err_at) begin
          mem_err_i = 1'b1;
        end else begin
          mem_ack_i  = 1'b1;
          mem_data_i = mem_val(mem_addr_o);
        end
      end
    end
  end

  task automatic push_reads(input logic [23:0] b, input int n);
    logic [23:0] a;
    for (int i = 0; i < n; i++) begin
      a = b + 24'(i);
      exp_mem.push_back('{addr: a, we: 1'b0, data: 16'd0});
      exp_rd.push_back(mem_val(a));
    end
  endtask

  task automatic send_hdr(input logic [15:0] w0, input logic [15:0] w1);
    @(negedge i_clk);
    bus_req_i  = 1'b1;
    bus_data_i = w0;
    @(negedge i_clk);
    bus_req_i  = 1'b0;
    bus_data_i = w1;
    @(negedge i_clk);
    check("hdr_ack", 64'(bus_ack_o), 64'd1);
    check("hdr_oe", 64'(bus_data_oe), 64'd0);
  endtask

  task automatic wait_evt(output logic a, output logic e);
    int n = 0;
    @(negedge i_clk);
    while (!bus_ack_o && !bus_err_o && n < 400) begin
      @(negedge i_clk);
      n++;
    end
    a = bus_ack_o;
    e = bus_err_o;
    if (!a && !e) check("evt_bound", 64'(n), 64'd0);
  endtask

  task automatic read_beats(input int n, input bit err_end);
    logic a, e;
    logic [15:0] d;
    for (int i = 0; i < n; i++) begin
      wait_evt(a, e);
      check("rd_ack", 64'(a), 64'd1);
      check("rd_err", 64'(e), 64'd0);
      if (exp_rd.size() == 0) begin
        check("rd_q", 64'(exp_rd.size()), 64'd1);
        d = '0;
      end else begin
        d = exp_rd.pop_front();
      end
      check("rd_data", 64'(bus_data_o), 64'(d));
      check("rd_oe", 64'(bus_data_oe), 64'd1);
    end
    if (err_end) begin
      wait_evt(a, e);
      check("err_pulse", 64'(e), 64'd1);
      check("err_noack", 64'(a), 64'd0);
      @(negedge i_clk);
      check("err_len", 64'(bus_err_o), 64'd0);
      check("err_req_drop", 64'(mem_req_o), 64'd0);
    end
  endtask

  task automatic finish_test(input string tag);
    bus_dir_i = 1'b0;
    repeat (3) @(negedge i_clk);
    check({tag, "_memq"}, 64'(exp_mem.size()), 64'd0);
    check({tag, "_rdq"}, 64'(exp_rd.size()), 64'd0);
    check({tag, "_idle"}, 64'({bus_ack_o, bus_err_o, mem_req_o}), 64'd0);
  endtask

  function automatic logic [63:0] all_out();
    return {3'd0, bus_data_o, bus_data_oe, bus_ack_o, bus_err_o,
            mem_req_o, mem_we_o, mem_addr_o, mem_data_o};
  endfunction

  initial begin
    logic a, e, seen;
    int cnt;

    repeat (3) @(negedge i_clk);
    check("reset_outs", all_out(), 64'd0);
    i_rst = 1'b0;

    // Single read with a delayed turnaround
    req_n = 0;
    push_reads(24'h000100, 1);
    send_hdr(16'h0014, 16'h0100);
    repeat (6) @(negedge i_clk);
    check("turn_ack", 64'(bus_ack_o), 64'd0);
    check("turn_oe", 64'(bus_data_oe), 64'd0);
    check("turn_req_drop", 64'(mem_req_o), 64'd0);
    bus_dir_i = 1'b1;
    read_beats(1, 1'b0);
    @(negedge i_clk);
    check("gap_ack", 64'(bus_ack_o), 64'd0);
    check("gap_hold", 64'(bus_data_o), 64'hA0A0);
    finish_test("single");

    // Burst read
    req_n = 0;
    push_reads(24'hFFE000, 8);
    send_hdr(16'hFF16, 16'hE000);
    bus_dir_i = 1'b1;
    read_beats(8, 1'b0);
    finish_test("burst_rd");

    // Burst write
    req_n = 0;
    lat = 3;
    for (int i = 0; i < 8; i++)
      exp_mem.push_back('{addr: 24'h80 + 24'(i), we: 1'b1,
                          data: 16'(i + 1)});
    send_hdr(16'h0003, 16'h0080);
    bus_data_i = 16'h0001;
    for (int i = 0; i < 8; i++) begin
      wait_evt(a, e);
      check("wr_ack", 64'(a), 64'd1);
      check("wr_oe", 64'(bus_data_oe), 64'd0);
      bus_data_i = 16'(i + 2);
    end
    lat = 2;
    finish_test("burst_wr");

    // Address wrap
    req_n = 0;
    push_reads(24'hFFFFFE, 8);
    send_hdr(16'hFF16, 16'hFFFE);
    bus_dir_i = 1'b1;
    read_beats(8, 1'b0);
    finish_test("wrap");

    // Memory error on third beat
    req_n = 0;
    err_at = 3;
    push_reads(24'h123000, 3);
    void'(exp_rd.pop_back());
    send_hdr(16'h1202, 16'h3000);
    bus_dir_i = 1'b1;
    read_beats(2, 1'b1);
    seen = 1'b0;
    repeat (10) begin
      @(negedge i_clk);
      seen = seen | mem_req_o | bus_ack_o;
    end
    check("no_beat4", 64'(seen), 64'd0);
    err_at = 0;
    finish_test("memerr");

    // Timeout with no memory response
    req_n = 0;
    hang = 1'b1;
    push_reads(24'h000200, 1);
    void'(exp_rd.pop_back());
    send_hdr(16'h0000, 16'h0200);
    bus_dir_i = 1'b1;
    cnt = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge i_clk);
      if (bus_err_o) break;
      if (mem_req_o) cnt++;
    end
    check("to_err", 64'(bus_err_o), 64'd1);
    check("to_cycles", 64'(cnt), 64'd255);
    check("to_req_drop", 64'(mem_req_o), 64'd0);
    @(negedge i_clk);
    check("to_err_len", 64'(bus_err_o), 64'd0);
    hang = 1'b0;
    finish_test("timeout");

    // Reset in the middle of a burst, then a fresh single read
    req_n = 0;
    push_reads(24'h000400, 8);
    send_hdr(16'h0002, 16'h0400);
    bus_dir_i = 1'b1;
    read_beats(4, 1'b0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("midrst_outs", all_out(), 64'd0);
    i_rst = 1'b0;
    exp_mem.delete();
    exp_rd.delete();
    bus_dir_i = 1'b0;
    req_n = 0;
    push_reads(24'h000100, 1);
    send_hdr(16'h0000, 16'h0100);
    bus_dir_i = 1'b1;
    read_beats(1, 1'b0);
    finish_test("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
